// File: rtl/i2c_pkg.sv
// Shared FSM states, bus-level constants and the majority helper for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_PTR   = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One I2C line: 2-flop synchronizer, optional 3-sample majority filter
// (I2C_TGT_GLITCH_FILTER_EN) and registered rise/fall detect.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       filt;

    always_ff @(posedge clk) begin
        sync <= {sync[0], din};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        hist <= {hist[0], sync[1]};
    end

    assign filt = maj3(sync[1], hist[0], hist[1]);
`else
    assign filt = sync[1];
`endif

    // Level keeps tracking the pin through reset so no phantom edge appears on release.
    always_ff @(posedge clk) begin
        level <= filt;
        if (!rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= filt & ~level;
            fall <= ~filt & level;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register bank, pointer-then-data access and a local
// preload port. Optional SCL/SDA glitch filter: define I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         NREG     = 16,
    parameter int         PW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          loc_we,
    input  logic [PW-1:0] loc_addr,
    input  logic [7:0]    loc_data,
    output logic          bus_wr_valid,
    output logic [PW-1:0] bus_wr_addr,
    output logic [7:0]    bus_wr_data,
    output logic          busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_e    state;
    logic [3:0]    bitcnt;
    logic [7:0]    shreg;
    logic [PW-1:0] ptr;
    logic          mack;
    logic [7:0]    regs [NREG];

    logic       start_det, stop_det, bus_we;
    logic [7:0] rx_byte;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shreg[6:0], sda_lvl};
    assign bus_we    = (state == ST_WR_DATA) && scl_rise && (bitcnt == 4'd7)
                       && !start_det && !stop_det;

    // bitcnt counts SCL rises 0..8; in write states 9 marks the ACK clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bitcnt       <= 4'd0;
            shreg        <= 8'h00;
            ptr          <= '0;
            mack         <= I2C_NACK;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            bus_wr_valid <= 1'b0;
            bus_wr_addr  <= '0;
            bus_wr_data  <= 8'h00;
        end else begin
            bus_wr_valid <= 1'b0;
            if (start_det) begin
                state  <= ST_ADDR;
                bitcnt <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            shreg  <= rx_byte;
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= ~I2C_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bitcnt <= 4'd0;
                            if (shreg[0] == I2C_RW_READ) begin
                                state  <= ST_RD_DATA;
                                shreg  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                state  <= ST_WR_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_WR_PTR, ST_WR_DATA: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            shreg  <= rx_byte;
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd7 && state == ST_WR_PTR) begin
                                ptr <= rx_byte[PW-1:0];
                            end
                            if (bus_we) begin
                                bus_wr_valid <= 1'b1;
                                bus_wr_addr  <= ptr;
                                bus_wr_data  <= rx_byte;
                                ptr          <= ptr + 1'b1;
                            end
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            sda_oe <= ~I2C_ACK;
                            bitcnt <= 4'd9;
                        end else if (scl_fall && bitcnt == 4'd9) begin
                            sda_oe <= 1'b0;
                            bitcnt <= 4'd0;
                            state  <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            state  <= ST_RD_ACK;
                            sda_oe <= 1'b0;
                            ptr    <= ptr + 1'b1;
                        end else if (scl_fall && bitcnt != 4'd0) begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            mack <= sda_lvl;
                        end else if (scl_fall) begin
                            bitcnt <= 4'd0;
                            if (mack == I2C_NACK) begin
                                state <= ST_IGNORE;
                            end else begin
                                state  <= ST_RD_DATA;
                                shreg  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A bus write to the same register as a local write takes precedence.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst) begin
                regs[i] <= 8'h00;
            end else if (bus_we && ptr == PW'(i)) begin
                regs[i] <= rx_byte;
            end else if (loc_we && loc_addr == PW'(i)) begin
                regs[i] <= loc_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C controller with hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int HP = 20;
    localparam int Q  = 10;
`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int LAT = 4;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic       loc_we = 1'b0;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_data = 8'h00;
    logic       bus_wr_valid;
    logic [3:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;

    assign sda_i = sda_m & ~sda_oe;

    i2c_target dut (
        .clk          (clk),
        .rst          (rst),
        .scl_i        (scl_m),
        .sda_i        (sda_i),
        .sda_oe       (sda_oe),
        .loc_we       (loc_we),
        .loc_addr     (loc_addr),
        .loc_data     (loc_data),
        .bus_wr_valid (bus_wr_valid),
        .bus_wr_addr  (bus_wr_addr),
        .bus_wr_data  (bus_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         wr_pulses = 0;
    int         oe_cnt = 0;
    logic [3:0] last_addr = 4'd0, prev_addr = 4'd0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;

    always @(posedge clk) begin
        if (bus_wr_valid) begin
            wr_pulses <= wr_pulses + 1;
            prev_addr <= last_addr;
            prev_data <= last_data;
            last_addr <= bus_wr_addr;
            last_data <= bus_wr_data;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(HP);
        sda_m = 1'b0; tick(HP);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(HP);
        sda_m = 1'b1; tick(HP);
    endtask

    // mode 1: 1-clk SCL glitch in the low phase; mode 2: local write lands on the commit clk
    task automatic send_bit(input logic b, input int mode);
        sda_m = b; tick(Q);
        if (mode == 1) begin
            scl_m = 1'b1; tick(1);
            scl_m = 1'b0; tick(Q);
        end
        scl_m = 1'b1;
        if (mode == 2) begin
            tick(LAT);
            loc_we = 1'b1; tick(1);
            loc_we = 1'b0;
            chk("collide_valid", 32'(bus_wr_valid), 1);
            tick(HP - LAT - 1);
        end else begin
            tick(HP);
        end
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int mode, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], (mode == 1 && i == 7) ? 1 : ((mode == 2 && i == 0) ? 2 : 0));
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(HP / 2);
        ack = sda_i;  tick(HP / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(HP / 2);
            d[i] = sda_i; tick(HP / 2);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = ack_bit; tick(Q);
        scl_m = 1'b1;    tick(HP);
        scl_m = 1'b0;    tick(Q);
        sda_m = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic a0, a1, a2;
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(a, 0, a1);
        write_byte(d, 0, a2);
        i2c_stop();
        chk("wr_acks", 32'({a0, a1, a2}), 0);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        logic a0, a1, a2;
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(a, 0, a1);
        i2c_start();
        write_byte(8'hD1, 0, a2);
        read_byte(1'b1, d);
        i2c_stop();
        chk("rd_acks", 32'({a0, a1, a2}), 0);
    endtask

    task automatic loc_wr(input logic [3:0] a, input logic [7:0] d);
        loc_addr = a; loc_data = d; loc_we = 1'b1; tick(1);
        loc_we = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1;
        logic [2:0] bits3;
        int         p0, oe0;

        tick(6);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_valid", 32'(bus_wr_valid), 0);
        chk("rst_wr_addr", 32'(bus_wr_addr), 0);
        chk("rst_wr_data", 32'(bus_wr_data), 0);
        rst = 1'b1;
        tick(6);

        // pointer write then two data bytes
        p0 = wr_pulses;
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h3B, 0, a1);
        write_byte(8'hA5, 0, a2);
        write_byte(8'h5A, 0, a3);
        chk("busy_in_frame", 32'(busy), 1);
        i2c_stop();
        chk("t1_acks", 32'({a0, a1, a2, a3}), 0);
        chk("busy_after_stop", 32'(busy), 0);
        chk("t1_pulses", 32'(wr_pulses - p0), 2);
        chk("t1_addr0", 32'(prev_addr), 'hB);
        chk("t1_data0", 32'(prev_data), 'hA5);
        chk("t1_addr1", 32'(last_addr), 'hC);
        chk("t1_data1", 32'(last_data), 'h5A);
        rd_reg(8'h0B, d0);
        chk("t1_reg_b", 32'(d0), 'hA5);
        rd_reg(8'h0C, d0);
        chk("t1_reg_c", 32'(d0), 'h5A);

        // wrap-around read via repeated START
        loc_wr(4'hF, 8'h9C);
        loc_wr(4'h0, 8'h42);
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h0F, 0, a1);
        i2c_start();
        write_byte(8'hD1, 0, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        chk("t2_acks", 32'({a0, a1, a2}), 0);
        chk("t2_rd15", 32'(d0), 'h9C);
        chk("t2_rd0", 32'(d1), 'h42);
        chk("t2_ptr", 32'(dut.ptr), 1);

        // address mismatch
        p0 = wr_pulses;
        oe0 = oe_cnt;
        i2c_start();
        write_byte(8'hA0, 0, a0);
        write_byte(8'h55, 0, a1);
        chk("t3_busy", 32'(busy), 1);
        i2c_stop();
        chk("t3_nack", 32'(a0), 1);
        chk("t3_oe_never", 32'(oe_cnt - oe0), 0);
        chk("t3_no_write", 32'(wr_pulses - p0), 0);
        chk("t3_busy_end", 32'(busy), 0);

        // same-clk local and bus writes
        loc_addr = 4'd3; loc_data = 8'h11;
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h03, 0, a1);
        write_byte(8'hC3, 2, a2);
        i2c_stop();
        rd_reg(8'h03, d0);
        chk("t4_same_addr", 32'(d0), 'hC3);
        loc_addr = 4'd4; loc_data = 8'h44;
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h03, 0, a1);
        write_byte(8'h3C, 2, a2);
        i2c_stop();
        rd_reg(8'h03, d0);
        chk("t4_bus_reg3", 32'(d0), 'h3C);
        rd_reg(8'h04, d0);
        chk("t4_loc_reg4", 32'(d0), 'h44);

        // reset during the 4th bit of a read of 0xE0
        loc_wr(4'h9, 8'hE0);
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h09, 0, a1);
        i2c_start();
        write_byte(8'hD1, 0, a2);
        for (int i = 2; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(HP / 2);
            bits3[i] = sda_i; tick(HP / 2);
            scl_m = 1'b0; tick(Q);
        end
        chk("t5_first_bits", 32'(bits3), 'b111);
        chk("t5_drive_bit4", 32'(sda_oe), 1);
        rst = 1'b0;
        tick(1);
        chk("t5_rst_release", 32'(sda_oe), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        tick(3);
        rst = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(HP);
        wr_reg(8'h05, 8'h77);
        rd_reg(8'h05, d0);
        chk("t5_reg5", 32'(d0), 'h77);
        rd_reg(8'h06, d0);
        chk("t5_reg6_zero", 32'(d0), 0);
        rd_reg(8'h0B, d0);
        chk("t5_regb_zero", 32'(d0), 0);

        // SCL glitch before the MSB of a data byte
        i2c_start();
        write_byte(8'hD0, 0, a0);
        write_byte(8'h07, 0, a1);
        write_byte(8'h5A, 1, a2);
        i2c_stop();
        rd_reg(8'h07, d0);
        chk("t6_glitch", 32'(d0), FILT ? 'h5A : 'h2D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
